// File: rtl/fir_rns_channel.sv
// One residue channel of the RNS FIR: y[n] = (sum_k c[k]*x[n-k]) mod MOD.
// Three-stage valid/ready pipeline with run-time coefficient load and flush.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   flush      synchronous clear of delay line and pipeline (coefs kept)
//   in_valid   input sample valid
//   in_ready   block can accept a sample (combinational)
//   in_data    input residue, reduced mod MOD on entry
//   out_valid  output sample valid
//   out_ready  downstream accepts the output
//   out_data   filtered residue, 0..MOD-1
//   coef_we    coefficient write strobe
//   coef_addr  tap index k; indices >= TAPS are ignored
//   coef_data  coefficient value, reduced mod MOD on write
module fir_rns_channel #(
    parameter int W    = 8,
    parameter int TAPS = 6,
    parameter int MOD  = 251
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [W-1:0]            coef_data
);

    localparam int PW = 2 * W;
    localparam int SW = W + $clog2(TAPS);
    localparam logic [PW-1:0] MOD_P = PW'(MOD);
    localparam logic [SW-1:0] MOD_S = SW'(MOD);

    logic [W-1:0]  tap      [TAPS];
    logic [W-1:0]  coef     [TAPS];
    logic [W-1:0]  prod     [TAPS];
    logic [W-1:0]  prod_mod [TAPS];
    logic          v1;
    logic          v2;
    logic          stall;
    logic          accept;
    logic [W-1:0]  din_mod;
    logic [W-1:0]  coef_mod;
    logic [SW-1:0] acc_sum;
    logic [W-1:0]  sum_mod;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~flush;
    assign accept   = in_valid & in_ready;

    assign din_mod  = W'(PW'(in_data) % MOD_P);
    assign coef_mod = W'(PW'(coef_data) % MOD_P);

    // S2 input: per-tap modular products at full 2W width.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_mod[k] = W'((PW'(coef[k]) * PW'(tap[k])) % MOD_P);
        end
    end

    // S3 input: SW bits hold TAPS residues without overflow.
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_sum = acc_sum + SW'(prod[k]);
        end
        sum_mod = W'(acc_sum % MOD_S);
    end

    // Coefficients survive flush; writes land even while stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= W'(1);
            end
        end else if (coef_we && (int'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_mod;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                tap[k]  <= '0;
                prod[k] <= '0;
            end
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                tap[k] <= '0;
            end
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            // Delay line moves only on a real sample; bubbles leave it.
            if (accept) begin
                tap[0] <= din_mod;
                for (int k = 1; k < TAPS; k++) begin
                    tap[k] <= tap[k-1];
                end
            end
            v1 <= accept;
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= prod_mod[k];
            end
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                out_data <= sum_mod;
            end
        end
    end

endmodule

// File: tb/tb_fir_rns_channel.sv
// Bench for fir_rns_channel: directed cases plus random traffic
// scored against a history-queue model of the modular FIR sum.
module tb_fir_rns_channel;

    localparam int W    = 8;
    localparam int TAPS = 6;
    localparam int MOD  = 251;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         coef_we;
    logic [2:0]   coef_addr;
    logic [W-1:0] coef_data;

    fir_rns_channel #(.W(W), .TAPS(TAPS), .MOD(MOD)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int coef_m [TAPS];
    int hist   [$];
    int exp_q  [$];
    int outs   [$];
    int ref_outs [$];
    bit last_acc;

    int t1_exp [7]  = '{1, 2, 3, 3, 2, 1, 0};
    // x = -1 mod 251, so each output is -(prefix sum of coefs) mod 251
    int t2_exp [8]  = '{250, 248, 245, 242, 240, 239, 239, 239};
    int t5_exp [10] = '{1, 2, 3, 4, 5, 6, 6, 10, 10, 10};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_out();
        int s = 0;
        for (int k = 0; k < hist.size(); k++) begin
            s += coef_m[k] * hist[k];
        end
        return s % MOD;
    endfunction

    // One clock: called at the falling edge with inputs already driven.
    task automatic tick();
        logic         ov;
        logic         ir;
        logic [W-1:0] od;
        bit           acc;
        bit           pop;
        bit           stl;
        int           e;
        #1;
        ov  = out_valid;
        od  = out_data;
        ir  = in_ready;
        chk("in_ready", 32'(ir), 32'(!(ov && !out_ready) && !flush));
        acc = reset && in_valid && ir;
        pop = reset && !flush && ov && out_ready;
        stl = reset && !flush && ov && !out_ready;
        @(posedge clk);
        if (!reset) begin
            hist.delete();
            exp_q.delete();
            for (int k = 0; k < TAPS; k++) coef_m[k] = 1;
        end else begin
            if (coef_we && int'(coef_addr) < TAPS)
                coef_m[coef_addr] = int'(coef_data) % MOD;
            if (flush) begin
                hist.delete();
                exp_q.delete();
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(od), 32'(e));
                    outs.push_back(int'(od));
                end
            end
            if (acc) begin
                hist.push_front(int'(in_data) % MOD);
                if (hist.size() > TAPS) void'(hist.pop_back());
                exp_q.push_back(model_out());
            end
        end
        last_acc = acc;
        @(negedge clk);
        if (stl) begin
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_data", 32'(out_data), 32'(od));
        end
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic wcoef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 8'(d);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    task automatic stream_1_to_10(input bit with_stall);
        int x   = 1;
        int cyc = 0;
        outs.delete();
        while (x <= 10 && cyc < 40) begin
            in_valid  = 1'b1;
            in_data   = 8'(x);
            out_ready = !(with_stall && cyc >= 5 && cyc < 8);
            if (with_stall && cyc == 5) begin
                #1;
                chk("t4_in_ready_low", 32'(in_ready), 32'(0));
            end
            tick();
            if (last_acc) x++;
            cyc++;
        end
        chk("t4_sent", 32'(x), 32'(11));
        idle(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        for (int k = 0; k < TAPS; k++) coef_m[k] = 1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        reset = 1'b1;

        // T3: input reduction with default unit coefs
        outs.delete();
        in_valid = 1'b1;
        in_data  = 8'd255;
        tick();
        idle(4);
        chk("t3_count", 32'(outs.size()), 32'(1));
        chk("t3_out", 32'(outs.size() > 0 ? outs[0] : -1), 32'(4));

        // T1: impulse response and latency
        do_flush();
        wcoef(0, 1); wcoef(1, 2); wcoef(2, 3);
        wcoef(3, 3); wcoef(4, 2); wcoef(5, 1);
        idle(1);
        outs.delete();
        in_valid = 1'b1;
        in_data  = 8'd1;
        tick();
        chk("t1_lat_t", 32'(out_valid), 32'(0));
        in_data = 8'd0;
        tick();
        chk("t1_lat_t1", 32'(out_valid), 32'(0));
        tick();
        chk("t1_lat_t2_valid", 32'(out_valid), 32'(1));
        chk("t1_lat_t2_data", 32'(out_data), 32'(1));
        repeat (4) tick();
        idle(4);
        chk("t1_count", 32'(outs.size()), 32'(7));
        for (int j = 0; j < 7; j++)
            chk("t1_out", 32'(j < outs.size() ? outs[j] : -1), 32'(t1_exp[j]));

        // T2: wrap-around with constant 250
        do_flush();
        outs.delete();
        in_valid = 1'b1;
        in_data  = 8'd250;
        repeat (8) tick();
        idle(4);
        chk("t2_count", 32'(outs.size()), 32'(8));
        for (int j = 0; j < 8; j++)
            chk("t2_out", 32'(j < outs.size() ? outs[j] : -1), 32'(t2_exp[j]));

        // T4: backpressure must not change the output sequence
        do_flush();
        stream_1_to_10(1'b0);
        ref_outs = outs;
        do_flush();
        stream_1_to_10(1'b1);
        chk("t4_count", 32'(outs.size()), 32'(ref_outs.size()));
        for (int j = 0; j < ref_outs.size(); j++)
            chk("t4_out", 32'(j < outs.size() ? outs[j] : -1), 32'(ref_outs[j]));

        // T5: coef write mid-stream, out-of-range addresses ignored
        do_flush();
        for (int k = 0; k < TAPS; k++) wcoef(k, 1);
        wcoef(6, 9);
        wcoef(7, 9);
        idle(1);
        outs.delete();
        for (int j = 0; j < 10; j++) begin
            in_valid  = 1'b1;
            in_data   = 8'd1;
            coef_we   = (j == 7);
            coef_addr = 3'd0;
            coef_data = 8'd5;
            tick();
        end
        idle(4);
        chk("t5_count", 32'(outs.size()), 32'(10));
        for (int j = 0; j < 10; j++)
            chk("t5_out", 32'(j < outs.size() ? outs[j] : -1), 32'(t5_exp[j]));

        // T6: flush over a stalled output and a valid input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd3;
        i = 0;
        while (!out_valid && i < 8) begin
            tick();
            i++;
        end
        tick();
        chk("t6_stalled", 32'(out_valid), 32'(1));
        flush   = 1'b1;
        in_data = 8'd1;
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'(0));
        tick();
        chk("t6_flush_valid", 32'(out_valid), 32'(0));
        flush     = 1'b0;
        out_ready = 1'b1;
        outs.delete();
        in_valid = 1'b1;
        in_data  = 8'd1;
        tick();
        idle(4);
        chk("t6_count", 32'(outs.size()), 32'(1));
        chk("t6_coef_kept", 32'(outs.size() > 0 ? outs[0] : -1), 32'(5));
        reset = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(out_valid), 32'(0));
        chk("t6_rst_data", 32'(out_data), 32'(0));
        reset = 1'b1;
        outs.delete();
        in_valid = 1'b1;
        in_data  = 8'd7;
        tick();
        idle(4);
        chk("t6_rst_coef", 32'(outs.size() > 0 ? outs[0] : -1), 32'(7));

        // Random traffic against the model
        for (int k = 0; k < TAPS; k++) wcoef(k, int'($urandom_range(0, 255)));
        idle(1);
        for (int c = 0; c < 800; c++) begin
            flush     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle(8);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
